// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 4-bit interface engines.
//   - Request command encodings (CMD_*).
//   - Default bus timing constants in clk cycles at 100 MHz, shared with
//     the write sequencer.
//   - Read engine state enum.
package lcd_pkg;

    localparam logic [1:0] CMD_STATUS = 2'b00;
    localparam logic [1:0] CMD_DATA   = 2'b01;
    localparam logic [1:0] CMD_WAIT   = 2'b10;

    localparam int LCD_T_AS      = 8;   // RS/RW setup before E rise
    localparam int LCD_T_PW      = 48;  // E high time
    localparam int LCD_T_H       = 4;   // hold after E fall
    localparam int LCD_T_REC     = 52;  // extra E low between nibbles
    localparam int LCD_MAX_POLLS = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_RECOVER,
        ST_RESP
    } rd_state_t;

endpackage

// File: rtl/lcd_sync4.sv
// lcd_sync4: 4-bit two-flop synchronizer for the asynchronous LCD data pins.
//   clk, rst_n : clock, asynchronous active-low reset (clears both stages)
//   d_in       : asynchronous input
//   d_out      : input resynchronized to clk, two cycles of latency
module lcd_sync4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'h0;
            sync_q <= 4'h0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q;

endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: read-side engine for an HD44780 LCD in 4-bit mode.
// Performs two nibble read cycles per access (high nibble first) and returns
// the reassembled byte. Wait mode repeats status reads until BF clears or
// MAX_POLLS reads have been made.
//   clk, rst_n     : 100 MHz clock, asynchronous active-low reset
//   req_valid/cmd  : request (00 status, 01 data, 10 wait-not-busy, 11 = 00)
//   req_ready      : high while IDLE
//   rsp_valid      : one-cycle completion pulse, no backpressure
//   rsp_data       : byte read ({BF, AC} for status), held until next response
//   rsp_timeout    : with rsp_valid, wait mode ended with BF still set
//   lcd_d_in       : D7..D4 pins (asynchronous)
//   lcd_e/rs/rw    : registered LCD control pins
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_AS      = LCD_T_AS,
    parameter int T_PW      = LCD_T_PW,
    parameter int T_H       = LCD_T_H,
    parameter int T_REC     = LCD_T_REC,
    parameter int MAX_POLLS = LCD_MAX_POLLS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_cmd,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    input  logic [3:0] lcd_d_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    localparam int CNT_MAX = (T_AS > T_PW) ?
                             ((T_AS > T_H) ? ((T_AS > T_REC) ? T_AS : T_REC)
                                           : ((T_H > T_REC) ? T_H : T_REC)) :
                             ((T_PW > T_H) ? ((T_PW > T_REC) ? T_PW : T_REC)
                                           : ((T_H > T_REC) ? T_H : T_REC));
    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int POLL_W = $clog2(MAX_POLLS + 1);

    rd_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POLL_W-1:0]  poll_q, poll_d;
    logic               nib_q, nib_d;
    logic               wait_q, wait_d;
    logic               rs_q, rs_d;
    logic               rw_q, rw_d;
    logic               e_q, e_d;
    logic [7:0]         byte_q, byte_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic [3:0]         d_sync;

    lcd_sync4 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (lcd_d_in),
        .d_out (d_sync)
    );

    // Pin values are computed for the next state so that lcd_e/rs/rw come
    // straight from flops and line up with the state they belong to.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        poll_d        = poll_q;
        nib_d         = nib_q;
        wait_d        = wait_q;
        rs_d          = rs_q;
        rw_d          = rw_q;
        e_d           = 1'b0;
        byte_d        = byte_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wait_d  = (req_cmd == CMD_WAIT);
                    rs_d    = (req_cmd == CMD_DATA);
                    rw_d    = 1'b1;
                    poll_d  = '0;
                    nib_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(T_AS - 1)) begin
                    cnt_d   = '0;
                    e_d     = 1'b1;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == CNT_W'(T_PW - 1)) begin
                    // Last E-high cycle: data has long settled through the sync.
                    if (nib_q) byte_d[3:0] = d_sync;
                    else       byte_d[7:4] = d_sync;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    e_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(T_H - 1)) begin
                    cnt_d = '0;
                    if (!nib_q) begin
                        state_d = ST_RECOVER;
                    end else if (!wait_q ||
                                 !byte_q[7] ||
                                 (poll_q + POLL_W'(1)) == POLL_W'(MAX_POLLS)) begin
                        poll_d        = poll_q + POLL_W'(1);
                        state_d       = ST_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = byte_q;
                        rsp_timeout_d = wait_q & byte_q[7];
                    end else begin
                        // Another poll: nib stays 1 here and the RECOVER
                        // toggle brings it back to the high nibble.
                        poll_d  = poll_q + POLL_W'(1);
                        state_d = ST_RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                if (cnt_q == CNT_W'(T_REC - 1)) begin
                    cnt_d   = '0;
                    nib_d   = ~nib_q;
                    e_d     = 1'b1;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                rs_d    = 1'b0;
                rw_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                rs_d    = 1'b0;
                rw_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            poll_q        <= '0;
            nib_q         <= 1'b0;
            wait_q        <= 1'b0;
            rs_q          <= 1'b0;
            rw_q          <= 1'b0;
            e_q           <= 1'b0;
            byte_q        <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            poll_q        <= poll_d;
            nib_q         <= nib_d;
            wait_q        <= wait_d;
            rs_q          <= rs_d;
            rw_q          <= rw_d;
            e_q           <= e_d;
            byte_q        <= byte_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign lcd_e       = e_q;
    assign lcd_rs      = rs_q;
    assign lcd_rw      = rw_q;

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: scoreboard bench for lcd_reader (MAX_POLLS=4 so that both
// the poll-limit boundary and the timeout path are reachable quickly).
module tb_lcd_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_cmd = 2'b00;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic [3:0] lcd_d_in = 4'h0;
    logic       lcd_e, lcd_rs, lcd_rw;

    lcd_reader #(.MAX_POLLS(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .lcd_d_in    (lcd_d_in),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       to;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    int         hs_q[$];
    int         hs_log[$];
    logic [3:0] mdl_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         e_rise = 0;
    logic       cur_rs = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake cycle = the IDLE cycle whose closing edge accepts the request.
    always @(negedge clk) begin
        if (rst_n && req_valid && req_ready) begin
            hs_q.push_back(cyc);
            hs_log.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   h;
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexp_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                h = (hs_q.size() != 0) ? hs_q.pop_front() : -100000;
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_to", rsp_timeout, e.to);
                chk("rsp_lat", cyc - h, e.lat);
            end
        end
    end

    // LCD model: garbage right after E rises, real nibble 20 cycles later.
    always @(posedge lcd_e) begin
        logic [3:0] n;
        e_rise++;
        n = (mdl_q.size() != 0) ? mdl_q.pop_front() : 4'h0;
        #1;
        chk("rw_at_rise", lcd_rw, 1);
        chk("rs_at_rise", lcd_rs, cur_rs);
        lcd_d_in = ~n;
        repeat (20) @(posedge clk);
        lcd_d_in = n;
    end

    always @(negedge lcd_e) begin
        #1;
        if (rst_n) begin
            chk("rw_at_fall", lcd_rw, 1);
            chk("rs_at_fall", lcd_rs, cur_rs);
        end
    end

    task automatic wait_ready();
        bit got = 0;
        for (int k = 0; k < 2000 && !got; k++) begin
            if (req_ready) got = 1;
            else @(negedge clk);
        end
        chk("hs_seen", got, 1);
    endtask

    task automatic do_req(input logic [1:0] cmd, input logic [7:0] d, input logic to,
                          input int lat, input bit pins);
        exp_t e;
        e.data = d; e.to = to; e.lat = lat;
        exp_q.push_back(e);
        cur_rs = (cmd == 2'b01);
        @(negedge clk);
        req_cmd   = cmd;
        req_valid = 1'b1;
        wait_ready();
        for (int j = 1; j <= lat + 1; j++) begin
            @(negedge clk);
            if (j == 1) req_valid = 1'b0;
            if (pins && j <= lat) begin
                chk("e_win", lcd_e, (j >= 9 && j <= 56) || (j >= 113 && j <= 160));
                chk("rw_txn", lcd_rw, 1);
                chk("rs_txn", lcd_rs, cur_rs);
            end
        end
        chk("rsp_hold", rsp_data, d);
        chk("rw_idle", lcd_rw, 0);
        chk("rdy_idle", req_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int er0;
        #23;
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_vld", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_to", rsp_timeout, 0);
        chk("rst_rdy", req_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Status read
        er0 = e_rise;
        mdl_q.push_back(4'h8); mdl_q.push_back(4'h5);
        do_req(2'b00, 8'h85, 1'b0, 165, 1'b1);
        chk("e_cnt_status", e_rise - er0, 2);

        // Data read
        mdl_q.push_back(4'h4); mdl_q.push_back(4'h1);
        do_req(2'b01, 8'h41, 1'b0, 165, 1'b1);

        // Wait mode: BF on 3 polls, clears on the 4th (also the poll limit)
        er0 = e_rise;
        for (int p = 0; p < 3; p++) begin
            mdl_q.push_back(4'h9); mdl_q.push_back(4'h3);
        end
        mdl_q.push_back(4'h0); mdl_q.push_back(4'h7);
        do_req(2'b10, 8'h07, 1'b0, 165 + 3 * 208, 1'b0);
        chk("e_cnt_wait", e_rise - er0, 8);

        // Wait timeout: BF stuck
        er0 = e_rise;
        for (int p = 0; p < 6; p++) begin
            mdl_q.push_back(4'h8); mdl_q.push_back(4'h0);
        end
        do_req(2'b10, 8'h80, 1'b1, 165 + 3 * 208, 1'b0);
        chk("e_cnt_tmo", e_rise - er0, 8);
        mdl_q.delete();

        // Reset mid-pulse
        cur_rs = 1'b0;
        mdl_q.push_back(4'hF); mdl_q.push_back(4'hF);
        @(negedge clk);
        req_cmd = 2'b00; req_valid = 1'b1;
        wait_ready();
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j == 1) req_valid = 1'b0;
        end
        chk("e_pre_rst", lcd_e, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_e", lcd_e, 0);
        chk("arst_rw", lcd_rw, 0);
        chk("arst_rs", lcd_rs, 0);
        chk("arst_vld", rsp_valid, 0);
        chk("arst_rdy", req_ready, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        hs_q.delete();
        mdl_q.delete();
        repeat (200) @(negedge clk);
        mdl_q.push_back(4'h3); mdl_q.push_back(4'hC);
        do_req(2'b00, 8'h3C, 1'b0, 165, 1'b1);

        // req_valid held high with cmd 11
        cur_rs = 1'b0;
        mdl_q.push_back(4'hA); mdl_q.push_back(4'h1);
        mdl_q.push_back(4'hB); mdl_q.push_back(4'h2);
        mdl_q.push_back(4'hC); mdl_q.push_back(4'h3);
        begin
            exp_t e;
            e.to = 1'b0; e.lat = 165;
            e.data = 8'hA1; exp_q.push_back(e);
            e.data = 8'hB2; exp_q.push_back(e);
            e.data = 8'hC3; exp_q.push_back(e);
        end
        hs_log.delete();
        @(negedge clk);
        req_cmd = 2'b11; req_valid = 1'b1;
        wait_ready();
        repeat (340) @(negedge clk);
        req_valid = 1'b0;
        repeat (200) @(negedge clk);
        chk("hs_count", hs_log.size(), 3);
        if (hs_log.size() == 3) begin
            chk("hs_gap1", hs_log[1] - hs_log[0], 166);
            chk("hs_gap2", hs_log[2] - hs_log[1], 166);
        end

        chk("exp_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side engine for the HD44780-compatible character LCD in 4-bit mode, the complement to the existing write-only LCD sequencer. It accepts a read request, drives RS/RW/E through two nibble read cycles, samples D7..D4, and returns the reassembled byte: busy flag plus address counter, or DDRAM/CGRAM data. It also polls the busy flag until it clears. It sits beside the write sequencer under the LCD top level. The top level tri-states the data pins whenever `lcd_rw` is high.

## Interface
- `T_AS`, 8: RS/RW setup cycles before the first E rise.
- `T_PW`, 48: E high time per nibble, in cycles.
- `T_H`, 4: RS/RW/data hold cycles after each E fall.
- `T_REC`, 52: additional E-low cycles between nibbles. The E period is T_PW+T_H+T_REC = 104 cycles, which meets the 1 µs minimum at 100 MHz.
- `MAX_POLLS`, 255: maximum number of status reads in wait mode.

Ports:
- `clk`, in, 1: system clock, 100 MHz.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, 1: request strobe.
- `req_cmd`, in, 2: 00 status read, 01 data read, 10 wait-not-busy, 11 treated as 00.
- `req_ready`, out, 1: high in IDLE only.
- `rsp_valid`, out, 1: one-cycle completion pulse. There is no backpressure.
- `rsp_data`, out, 8: byte read. For status reads this is {BF, AC[6:0]}.
- `rsp_timeout`, out, 1: valid with `rsp_valid`; 1 only when wait mode is exhausted.
- `lcd_d_in`, in, 4: D7..D4 pins, asynchronous.
- `lcd_e`, `lcd_rs`, `lcd_rw`, out, 1 each: LCD control pins.

## Operation
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_timeout`=0.
  - Poll count and synchronizer are cleared; state is IDLE.
  - `req_ready`=1, but requests are ignored while `rst_n`=0.
- States: IDLE, SETUP, PULSE, HOLD, RECOVER, RESP.
  - The nibble index `nib` (0 = high nibble, 1 = low nibble) and a cycle counter sized for max(T_AS, T_PW, T_H, T_REC) qualify the states.
- Handshake: `req_valid & req_ready` in IDLE latches `req_cmd`.
  - `lcd_rw` goes to 1; `lcd_rs` goes to 1 for cmd 01, else 0.
  - Poll count clears; state goes to SETUP with `nib`=0.
- SETUP: T_AS cycles with E=0, then PULSE.
- PULSE: T_PW cycles with E=1. On the final PULSE cycle the synchronized nibble is captured into byte bits [7:4] (`nib`=0) or [3:0] (`nib`=1). Then HOLD.
- HOLD: T_H cycles with E=0, RS/RW held. Exit depends on `nib`:
  - `nib`=0: go to RECOVER.
  - `nib`=1, not wait mode: go to RESP.
  - `nib`=1, wait mode: count the poll. If BF=0, or the poll count equals MAX_POLLS, go to RESP. Otherwise go to RECOVER with `nib` cleared to 0.
- RECOVER: T_REC cycles with E=0, then PULSE with `nib` toggled (or cleared, for a new poll).
- RESP: one cycle with `rsp_valid`=1 and `rsp_data`=captured byte.
  - `rsp_timeout`=1 iff wait mode ended with BF=1.
  - Next cycle: IDLE, `lcd_rw`=0, `lcd_rs`=0. `rsp_data` holds its value until the next RESP.
- Data input path: 2-flop synchronizer on `lcd_d_in`. The LCD data-valid delay of 360 ns (36 cycles) is well inside T_PW minus the 2 synchronizer cycles.
- RS/RW never change while E=1. E never rises less than T_AS cycles after RS/RW change.

## Timing
- The handshake edge is cycle 0. With default parameters:
  - SETUP: cycles 1–8.
  - First E high: cycles 9–56.
  - HOLD: 57–60.
  - RECOVER: 61–112.
  - Second E high: 113–160.
  - HOLD: 161–164.
  - `rsp_valid`: cycle 165.
- Single-read latency is T_AS + 2·T_PW + 2·T_H + T_REC + 1 = 165 cycles.
- Each additional poll adds 2·(T_PW+T_H+T_REC) = 208 cycles. The first poll of a wait-mode request has the same 165-cycle latency as a single read.
- `req_ready` rises in the cycle after RESP. The earliest back-to-back handshake is cycle 166.
- Pins are registered outputs: no glitches on `lcd_e`.

## Structure
- Package `lcd_pkg`:
  - Command encodings: CMD_STATUS, CMD_DATA, CMD_WAIT.
  - Default timing constants, shared with the write sequencer.
  - The state enum.
- Sub-module `lcd_sync4`: 4-bit 2-flop synchronizer with async active-low reset.
- FSM, counters, and capture live in `lcd_reader`.

## Test plan
- Status read: LCD model returns 0x8 then 0x5 → one `rsp_valid` at cycle 165 with `rsp_data`=0x85 and `rsp_timeout`=0. E is high for exactly cycles 9–56 and 113–160, RS=0, RW=1 throughout.
- Data read (cmd 01): model returns 0x4 then 0x1 → `rsp_data`=0x41 with RS=1 throughout. RS/RW are stable at both E edges.
- Wait mode: BF=1 on the first 3 polls, then model returns 0x0 and 0x7 → rsp at cycle 165 + 3·208 = 789 with `rsp_data`=0x07 and `rsp_timeout`=0.
- Wait timeout with MAX_POLLS=4: BF stuck at 1 and status nibbles 0x8 then 0x0 → exactly 4 status reads, then `rsp_timeout`=1 with `rsp_data`=0x80.
- Reset asserted at cycle 30 (mid-pulse): `lcd_e`, `lcd_rw`, `lcd_rs` go to 0 asynchronously and no `rsp_valid` is produced. After release, a new cmd 00 completes 165 cycles after its handshake.
- `req_valid` held high continuously plus cmd 11: each request is accepted only in IDLE and executes as a status read. Handshakes fall at cycle 0, 166, 332, and so on.
